// File: rtl/seven_seg_scan_pkg.sv
// Shared segment constants for the seven-segment scan driver.
// Segment bits are active-low in {g,f,e,d,c,b,a} order.
// An anode bit of 1 means that digit is off.
package seven_seg_scan_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

  // Anode value of a digit that is not driven (active-low pins).
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/seven_seg_scan_dec.sv
// Combinational hex-to-seven-segment decoder with a blank override.
module seven_seg_dec
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the nibble value; otherwise standard hex glyphs.
  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      case (nib_i)
        4'h0: seg_o = SEG_0;
        4'h1: seg_o = SEG_1;
        4'h2: seg_o = SEG_2;
        4'h3: seg_o = SEG_3;
        4'h4: seg_o = SEG_4;
        4'h5: seg_o = SEG_5;
        4'h6: seg_o = SEG_6;
        4'h7: seg_o = SEG_7;
        4'h8: seg_o = SEG_8;
        4'h9: seg_o = SEG_9;
        4'hA: seg_o = SEG_A;
        4'hB: seg_o = SEG_B;
        4'hC: seg_o = SEG_C;
        4'hD: seg_o = SEG_D;
        4'hE: seg_o = SEG_E;
        default: seg_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode display driver. Data is held in a
// pending buffer and moved to the displayed (shadow) copy only at frame
// boundaries so a frame never shows a mix of old and new digits.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  lamp_test,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0][3:0]    pend_data_q, pend_data_d;
  logic [DIGITS-1:0]         pend_dp_q, pend_dp_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0][3:0]    sh_data_q, sh_data_d;
  logic [DIGITS-1:0]         sh_dp_q, sh_dp_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      ft_q;

  logic                      slot_end;
  logic                      boundary;
  logic [DIGITS-1:0]         lz_blank;
  logic [6:0]                dec_seg;

  assign slot_end = en && (cnt_q == CNT_MAX);
  assign boundary = slot_end && (idx_q == IDX_MAX);

  // Prescaler and digit index; both freeze while scanning is disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: a load on the boundary cycle skips pending entirely,
  // otherwise it lands in pending and is committed at the next boundary.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_vld_d  = pend_vld_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    if (load) begin
      if (boundary) begin
        sh_data_d  = data;
        sh_dp_d    = dp_in;
        pend_vld_d = 1'b0;
      end else begin
        pend_data_d = data;
        pend_dp_d   = dp_in;
        pend_vld_d  = 1'b1;
      end
    end else if (boundary && pend_vld_q) begin
      sh_data_d  = pend_data_q;
      sh_dp_d    = pend_dp_q;
      pend_vld_d = 1'b0;
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above are 0.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (sh_data_q[i] == 4'h0);
      lz_blank[i] = blank_lz && zero_run;
    end
  end

  seven_seg_dec u_dec (
    .nib_i   (sh_data_q[idx_q]),
    .blank_i (lz_blank[idx_q]),
    .seg_o   (dec_seg)
  );

  // Next output values from the current scan position and shadow data.
  always_comb begin
    an_d  = {DIGITS{AN_OFF}};
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (en) begin
      if (cnt_q >= BLANK_C) an_d[idx_q] = ~AN_OFF;
      if (lamp_test) begin
        seg_d = SEG_ALL;
        dp_d  = 1'b0;
      end else begin
        seg_d = dec_seg;
        dp_d  = ~sh_dp_q[idx_q];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_vld_q  <= 1'b0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      an_q        <= {DIGITS{AN_OFF}};
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      ft_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_vld_q  <= pend_vld_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      ft_q        <= boundary;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: a frame-time reference model is
// compared every cycle, plus literal checks of the documented scenarios.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BL = 1;
  localparam int NF = ND * RD;

  logic            clk = 1'b0;
  logic            rst_n, en, load, blank_lz, lamp_test;
  logic [4*ND-1:0] data;
  logic [ND-1:0]   dp_in;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic            frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  seven_seg_scan #(.DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data),
    .dp_in(dp_in), .blank_lz(blank_lz), .lamp_test(lamp_test),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Reference model: t is the clock position within the frame.
  int         t;
  logic [15:0] m_sh, m_pd;
  logic [3:0]  m_shdp, m_pdp;
  logic        m_pv;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft;

  int          m_dig, m_pos;
  logic        m_bnd, m_lz;
  logic [3:0]  m_nib;
  assign m_dig = t / RD;
  assign m_pos = t % RD;
  assign m_bnd = en && (t == NF - 1);
  assign m_nib = 4'((m_sh >> (4 * m_dig)) & 16'hF);
  assign m_lz  = blank_lz && (m_dig > 0) && ((m_sh >> (4 * m_dig)) == 16'h0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0; m_sh <= '0; m_pd <= '0; m_shdp <= '0; m_pdp <= '0; m_pv <= 1'b0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_ft <= 1'b0;
    end else begin
      if (!en) begin
        e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1;
      end else begin
        e_an  <= (m_pos < BL) ? 4'hF : ~(4'b0001 << m_dig);
        e_seg <= lamp_test ? 7'h00 : (m_lz ? 7'h7F : glyph(m_nib));
        e_dp  <= lamp_test ? 1'b0 : ~m_shdp[m_dig];
      end
      e_ft <= m_bnd;
      if (en) t <= (t + 1) % NF;
      if (load) begin
        if (m_bnd) begin m_sh <= data; m_shdp <= dp_in; m_pv <= 1'b0; end
        else begin m_pd <= data; m_pdp <= dp_in; m_pv <= 1'b1; end
      end else if (m_bnd && m_pv) begin
        m_sh <= m_pd; m_shdp <= m_pdp; m_pv <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_an", 32'(an), 32'(e_an));
    check("model_seg", 32'(seg), 32'(e_seg));
    check("model_dp", 32'(dp), 32'(e_dp));
    check("model_ft", 32'(frame_tick), 32'(e_ft));
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    @(posedge clk); #1;
    load = 1'b1; data = d; dp_in = p;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_ft();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL wait_ft: got timeout expected frame_tick"); end
  endtask

  task automatic wait_lit(input int d, input string nm, input logic [6:0] es, input logic edp);
    logic [3:0] pat;
    bit seen = 0;
    pat = ~(4'b0001 << d);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (an == pat) seen = 1;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got timeout expected digit %0d lit", nm, d);
    end else begin
      check({nm, "_seg"}, 32'(seg), 32'(es));
      check({nm, "_dp"}, 32'(dp), 32'(edp));
    end
  endtask

  initial begin
    logic [3:0] seq [8];
    int ticks;
    seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; dp_in = '0;
    blank_lz = 1'b0; lamp_test = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_ft", 32'(frame_tick), 32'h0);

    // Scan sequence and frame tick rate after release.
    @(posedge clk); #1; rst_n = 1'b1; en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); @(negedge clk);
      if (i < 8) check("scan_seq", 32'(an), 32'(seq[i]));
      if (frame_tick) ticks++;
    end
    check("tick_count", 32'(ticks), 32'd2);

    // Load mid-frame, then read back all digits after commit.
    do_load(16'h12AF, 4'b0100);
    wait_ft();
    wait_lit(0, "ld_d0", 7'h0E, 1'b1);
    wait_lit(1, "ld_d1", 7'h08, 1'b1);
    wait_lit(2, "ld_d2", 7'h24, 1'b0);
    wait_lit(3, "ld_d3", 7'h79, 1'b1);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_ft();
    wait_lit(0, "lz_d0", 7'h40, 1'b1);
    wait_lit(1, "lz_d1", 7'h12, 1'b1);
    wait_lit(2, "lz_d2", 7'h7F, 1'b1);
    wait_lit(3, "lz_d3", 7'h7F, 1'b1);
    do_load(16'h0000, 4'b0000);
    wait_ft();
    wait_lit(0, "lz0_d0", 7'h40, 1'b1);
    wait_lit(1, "lz0_d1", 7'h7F, 1'b1);
    wait_lit(3, "lz0_d3", 7'h7F, 1'b1);
    blank_lz = 1'b0;

    // Last load wins.
    wait_ft();
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    wait_ft();
    wait_lit(0, "lw_d0", 7'h24, 1'b1);

    // Load exactly on the boundary cycle bypasses pending.
    wait_ft();
    repeat (15) @(posedge clk);
    #1; load = 1'b1; data = 16'h3333; dp_in = 4'b0000;
    @(posedge clk); #1; load = 1'b0;
    wait_ft();
    wait_lit(0, "byp_d0", 7'h30, 1'b1);
    wait_ft();
    wait_lit(3, "byp_d3", 7'h30, 1'b1);

    // Enable low: anodes off, position frozen (model tracks it).
    @(posedge clk); #1; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check("en_off_an", 32'(an), 32'hF);
    end
    #1; en = 1'b1;

    // Lamp test.
    lamp_test = 1'b1;
    wait_lit(2, "lamp_d2", 7'h00, 1'b0);
    wait_lit(3, "lamp_d3", 7'h00, 1'b0);
    #1; lamp_test = 1'b0;

    // Reset while a load is pending.
    wait_ft();
    do_load(16'h5555, 4'b1111);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_an", 32'(an), 32'hF);
    check("rst_mid_seg", 32'(seg), 32'h7F);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_ft();
    wait_ft();
    wait_lit(3, "rst_mid_d3", 7'h40, 1'b1);
    wait_lit(0, "rst_mid_d0", 7'h40, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      load      = ($urandom_range(7) == 0);
      data      = 16'($urandom);
      if ($urandom_range(3) == 0) data[15:8] = 8'h00;
      dp_in     = 4'($urandom);
      en        = ($urandom_range(9) != 0);
      lamp_test = ($urandom_range(19) == 0);
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
    end
    @(posedge clk); #1; load = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
